cacheline_arbiter: RTL and testbench
====================================

CACHELINE_ARBITER -- requirements
Module: cacheline_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, SHALL set the cacheline data width in bits.
REQ-002 Parameter ADDR_W, default 32, SHALL set the address width in bits.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 i_read  input  1  SHALL be the I-cache line-fill request, held until i_resp.
REQ-006 i_address  input  ADDR_W  SHALL be the I-cache line address.
REQ-007 i_rdata  output  LINE_W  SHALL be the fill data to the I-cache.
REQ-008 i_resp  output  1  SHALL be the I-cache completion pulse.
REQ-009 d_read / d_write  input  1 each  SHALL be the D-cache fill / writeback requests, held until d_resp.
REQ-010 d_address  input  ADDR_W  SHALL be the D-cache line address.
REQ-011 d_wdata  input  LINE_W  SHALL be the D-cache writeback data.
REQ-012 d_rdata  output  LINE_W  SHALL be the fill data to the D-cache.
REQ-013 d_resp  output  1  SHALL be the D-cache completion pulse.
REQ-014 pmem_read / pmem_write  output  1 each  SHALL be the shared memory-port requests.
REQ-015 pmem_address  output  ADDR_W  SHALL be the shared memory-port address.
REQ-016 pmem_wdata  output  LINE_W  SHALL be the shared memory-port write data.
REQ-017 pmem_rdata  input  LINE_W  SHALL be the shared memory-port read data.
REQ-018 pmem_resp  input  1  SHALL be the shared memory-port completion pulse.
REQ-019 grant  output  2  SHALL report the owner: 00 none, 01 I-cache, 10 D-cache.

Function
REQ-020 FSM states SHALL be IDLE, SERVE_I, SERVE_D; a last_grant register SHALL record the most recently served requester.
REQ-021 In IDLE, a pending request from exactly one side SHALL move the FSM to that side's SERVE state on the next edge.
REQ-022 In IDLE, simultaneous requests SHALL grant the side not equal to last_grant (round-robin); after reset, last_grant = I, so D wins the first tie.
REQ-023 In IDLE, all pmem_* requests SHALL be 0, grant = 00, i_resp = d_resp = 0.
REQ-024 In SERVE_I: pmem_read = i_read, pmem_write = 0, pmem_address = i_address with bits [4:0] forced to 0.
REQ-025 In SERVE_D: pmem_read = d_read & ~d_write, pmem_write = d_write, pmem_wdata = d_wdata, pmem_address = d_address with bits [4:0] forced to 0; a write wins if both d_read and d_write are high.
REQ-026 Arbitration latency SHALL be one cycle: the request is sampled in IDLE and pmem_* asserts in the following cycle.
REQ-027 i_rdata and d_rdata SHALL both be driven combinationally from pmem_rdata at all times.
REQ-028 i_resp SHALL equal pmem_resp only in SERVE_I; d_resp SHALL equal pmem_resp only in SERVE_D (same cycle, combinational).
REQ-029 On pmem_resp in SERVE_x, the FSM SHALL return to IDLE on the next edge and last_grant SHALL update to x.
REQ-030 pmem_resp received in IDLE SHALL be ignored: no resp forwarded, no state change.
REQ-031 A request withdrawn before pmem_resp (protocol violation) SHALL not cause an abort; the FSM SHALL remain in SERVE until pmem_resp.
REQ-032 The non-granted requester SHALL see no resp and SHALL be served no later than the next arbitration, so starvation is bounded to one transaction.
REQ-033 Back-to-back: the minimum spacing between two pmem transactions SHALL be one IDLE cycle.

Reset
REQ-034 While rst = 0: state = IDLE, last_grant = I, and on the following cycle all of pmem_read, pmem_write, i_resp, d_resp = 0 and grant = 00.
REQ-035 Reset asserted mid-transaction SHALL abandon it; a late pmem_resp after reset SHALL be ignored per REQ-030.

Verification
REQ-036 i_read = 1, i_address = 0x0000_1234; pmem_resp after 3 cycles -> pmem_read asserts 1 cycle after the request with pmem_address = 0x0000_1220; i_resp pulses 1 cycle with i_rdata = pmem_rdata; grant = 01.
REQ-037 i_read and d_write both asserted on the first cycle after reset -> D is served first (pmem_write = 1, pmem_wdata = d_wdata); after d_resp, I is served after one IDLE cycle.
REQ-038 Both requesters assert continuously, each transaction lasting 2 cycles -> grant alternates 10, 01, 10, 01 over 4 transactions.
REQ-039 d_read = d_write = 1 -> pmem_write = 1, pmem_read = 0.
REQ-040 rst = 0 during SERVE_D, then a stray pmem_resp arrives -> pmem_* = 0 and d_resp stays 0; the next request is arbitrated normally.
REQ-041 pmem_resp pulsed in IDLE with no requests -> i_resp = d_resp = 0 and grant stays 00.

Source files
------------

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter sharing one cacheline memory port between an I-cache and a D-cache.
// One transaction at a time; a single IDLE cycle always separates two transactions.
module cacheline_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic [1:0]        grant
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  typedef enum logic {
    LG_I = 1'b0,
    LG_D = 1'b1
  } last_e;

  state_e state_q, state_d;
  last_e  last_grant_q, last_grant_d;
  logic   d_req_s;

  // Line offset bits are dropped on the memory port.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{i_address[4:0], d_address[4:0]};

  assign d_req_s = d_read | d_write;

  // Next-state and round-robin bookkeeping.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      IDLE: begin
        if (i_read && d_req_s) begin
          if (last_grant_q == LG_I) begin
            state_d = SERVE_D;
          end else begin
            state_d = SERVE_I;
          end
        end else if (i_read) begin
          state_d = SERVE_I;
        end else if (d_req_s) begin
          state_d = SERVE_D;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = LG_I;
        end else begin
          state_d = SERVE_I;
        end
      end
      SERVE_D: begin
        if (pmem_resp) begin
          state_d      = IDLE;
          last_grant_d = LG_D;
        end else begin
          state_d = SERVE_D;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      last_grant_q <= LG_I;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Memory-port muxing and response steering; a D write wins over a D read.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = {ADDR_W{1'b0}};
    pmem_wdata   = {LINE_W{1'b0}};
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    grant        = 2'b00;
    case (state_q)
      IDLE: begin
        grant = 2'b00;
      end
      SERVE_I: begin
        pmem_read    = i_read;
        pmem_address = {i_address[ADDR_W-1:5], 5'b00000};
        i_resp       = pmem_resp;
        grant        = 2'b01;
      end
      SERVE_D: begin
        pmem_read    = d_read & ~d_write;
        pmem_write   = d_write;
        pmem_wdata   = d_wdata;
        pmem_address = {d_address[ADDR_W-1:5], 5'b00000};
        d_resp       = pmem_resp;
        grant        = 2'b10;
      end
      default: begin
        grant = 2'b00;
      end
    endcase
  end

  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Scoreboard bench for cacheline_arbiter: expected memory-port transactions are queued when
// requests are driven and compared as the arbiter issues them.
module tb_cacheline_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, pmem_resp;
  logic [AW-1:0] i_address, d_address;
  logic [LW-1:0] d_wdata, pmem_rdata;
  logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
  logic          i_resp, d_resp, pmem_read, pmem_write;
  logic [AW-1:0] pmem_address;
  logic [1:0]    grant;

  typedef struct {
    logic [1:0]    grant;
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t sb[$];
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  cacheline_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .grant(grant)
  );

  function automatic txn_t mk(input logic [1:0] g, input logic rd, input logic wr,
                              input logic [AW-1:0] a, input logic [LW-1:0] wd);
    txn_t t;
    t.grant = g; t.rd = rd; t.wr = wr;
    t.addr  = a & 32'hFFFF_FFE0;
    t.wdata = wd;
    return t;
  endfunction

  // Wait for the next memory-port transaction, compare it to the scoreboard, respond after lat cycles.
  task automatic serve(input int lat, input bit drop_i, input bit drop_d);
    int            n;
    txn_t          e;
    logic [LW-1:0] rdata;
    logic [1:0]    exp_resp;
    n = 0;
    while (!(pmem_read || pmem_write) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    total++;
    if (n !== 1) begin
      $display("FAIL issue_latency: got %0d cycles, expected 1", n);
      if (n >= 20) return;
    end else passed++;
    total++;
    if (sb.size() == 0) begin
      $display("FAIL sb_underflow: got unexpected transaction, expected none");
      return;
    end else passed++;
    e = sb.pop_front();
    total++;
    if ({grant, pmem_read, pmem_write, pmem_address} !== {e.grant, e.rd, e.wr, e.addr})
      $display("FAIL txn_ctrl: got grant=%b rd=%b wr=%b addr=%h, expected grant=%b rd=%b wr=%b addr=%h",
               grant, pmem_read, pmem_write, pmem_address, e.grant, e.rd, e.wr, e.addr);
    else passed++;
    if (e.wr) begin
      total++;
      if (pmem_wdata !== e.wdata) $display("FAIL txn_wdata: got %h, expected %h", pmem_wdata, e.wdata);
      else passed++;
    end
    repeat (lat - 1) @(posedge clk);
    #1;
    rdata      = {8{$urandom}};
    pmem_rdata = rdata;
    pmem_resp  = 1'b1;
    #1;
    exp_resp = (e.grant == 2'b01) ? 2'b10 : 2'b01;
    total++;
    if ({i_resp, d_resp} !== exp_resp)
      $display("FAIL resp_route: got i_resp,d_resp=%b, expected %b", {i_resp, d_resp}, exp_resp);
    else passed++;
    total++;
    if (i_rdata !== rdata || d_rdata !== rdata)
      $display("FAIL rdata_fwd: got i=%h d=%h, expected %h", i_rdata, d_rdata, rdata);
    else passed++;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    if (drop_i) i_read = 1'b0;
    if (drop_d) begin d_read = 1'b0; d_write = 1'b0; end
    #1;
    total++;
    if ({grant, i_resp, d_resp, pmem_read, pmem_write} !== 6'b000000)
      $display("FAIL idle_gap: got grant=%b resp=%b pmem=%b, expected all zero",
               grant, {i_resp, d_resp}, {pmem_read, pmem_write});
    else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_read = 1'b1; d_write = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({grant, pmem_read, pmem_write, i_resp, d_resp} !== 6'b000000)
      $display("FAIL reset_state: got grant=%b pmem=%b resp=%b, expected zeros",
               grant, {pmem_read, pmem_write}, {i_resp, d_resp});
    else passed++;
    i_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_tie_after_reset();
    rst       = 1'b1;
    i_read    = 1'b1; i_address = 32'h0000_4444;
    d_write   = 1'b1; d_address = 32'h0000_8888; d_wdata = {8{$urandom}};
    sb.push_back(mk(2'b10, 1'b0, 1'b1, d_address, d_wdata));
    sb.push_back(mk(2'b01, 1'b1, 1'b0, i_address, '0));
    serve(2, 1'b0, 1'b1);
    serve(2, 1'b1, 1'b0);
  endtask

  task automatic test_single_i();
    i_read = 1'b1; i_address = 32'h0000_1234;
    sb.push_back(mk(2'b01, 1'b1, 1'b0, 32'h0000_1220, '0));
    serve(3, 1'b1, 1'b0);
  endtask

  task automatic test_round_robin();
    i_read = 1'b1; i_address = 32'hABCD_007F;
    d_read = 1'b1; d_address = 32'h1357_9BDF;
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) sb.push_back(mk(2'b10, 1'b1, 1'b0, d_address, '0));
      else            sb.push_back(mk(2'b01, 1'b1, 1'b0, i_address, '0));
    end
    for (int k = 0; k < 4; k++) serve(2, k == 3, k == 3);
  endtask

  task automatic test_d_rw_both();
    d_read = 1'b1; d_write = 1'b1; d_address = 32'hFFFF_FFFF; d_wdata = {8{$urandom}};
    sb.push_back(mk(2'b10, 1'b0, 1'b1, d_address, d_wdata));
    serve(1, 1'b0, 1'b1);
  endtask

  task automatic test_withdraw();
    i_read = 1'b1; i_address = 32'h0000_0040;
    @(posedge clk); #1;
    i_read = 1'b0;
    @(posedge clk); #1;
    total++;
    if ({grant, pmem_read} !== 3'b010)
      $display("FAIL withdraw_hold: got grant=%b rd=%b, expected grant=01 rd=0", grant, pmem_read);
    else passed++;
    pmem_resp = 1'b1; #1;
    total++;
    if ({i_resp, d_resp} !== 2'b10) $display("FAIL withdraw_resp: got %b, expected 10", {i_resp, d_resp});
    else passed++;
    @(posedge clk); #1;
    pmem_resp = 1'b0; #1;
    total++;
    if (grant !== 2'b00) $display("FAIL withdraw_idle: got grant=%b, expected 00", grant);
    else passed++;
  endtask

  task automatic test_idle_resp();
    pmem_resp = 1'b1; #1;
    total++;
    if ({i_resp, d_resp, grant} !== 4'b0000)
      $display("FAIL idle_resp: got resp=%b grant=%b, expected 00/00", {i_resp, d_resp}, grant);
    else passed++;
    @(posedge clk); #1;
    pmem_resp = 1'b0; #1;
    total++;
    if ({grant, pmem_read, pmem_write} !== 4'b0000)
      $display("FAIL idle_resp_after: got grant=%b pmem=%b, expected zeros", grant, {pmem_read, pmem_write});
    else passed++;
  endtask

  task automatic test_reset_mid_txn();
    d_read = 1'b1; d_address = 32'h0000_2000;
    @(posedge clk); #1;
    total++;
    if ({grant, pmem_read} !== 3'b101) $display("FAIL mid_serve_d: got grant=%b rd=%b, expected 10/1", grant, pmem_read);
    else passed++;
    rst = 1'b0; d_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; pmem_resp = 1'b1; #1;
    total++;
    if ({grant, pmem_read, pmem_write, d_resp, i_resp} !== 6'b000000)
      $display("FAIL stray_resp: got grant=%b pmem=%b resp=%b, expected zeros",
               grant, {pmem_read, pmem_write}, {i_resp, d_resp});
    else passed++;
    @(posedge clk); #1;
    pmem_resp = 1'b0;
    i_read = 1'b1; i_address = 32'h0000_3033;
    sb.push_back(mk(2'b01, 1'b1, 1'b0, i_address, '0));
    serve(2, 1'b1, 1'b0);
  endtask

  initial begin
    rst = 1'b0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0; pmem_resp = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0; pmem_rdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_tie_after_reset();
    test_single_i();
    test_round_robin();
    test_d_rw_both();
    test_withdraw();
    test_idle_resp();
    test_reset_mid_txn();
    total++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size());
    else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
